// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers row/column/displayActive from an hSync/vSync pair and flags timing violations
// Ports:
//    clk, rst           pixel clock; synchronous active-low reset
//    hSync, vSync       incoming syncs, active level SYNC_POL
//    row, column        visible position, 0 outside the visible window
//    displayActive      visible region while locked
//    frameStart         pulse at row 0, column 0 while locked
//    locked             LOCK_FRAMES clean frames seen since the last violation
//    hErr, vErr         one-cycle violation pulses while locked
//    errCount           saturating count of violations seen while locked
module vga_sync_decoder #(
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter bit SYNC_POL    = 1'b0,
   parameter int LOCK_FRAMES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       hSync,
   input  logic       vSync,
   output logic [8:0] row,
   output logic [9:0] column,
   output logic       displayActive,
   output logic       frameStart,
   output logic       locked,
   output logic       hErr,
   output logic       vErr,
   output logic [7:0] errCount
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
   localparam logic [9:0] H_SYNC_LAST = 10'(H_SYNC - 1);
   localparam logic [9:0] H_START     = 10'(H_SYNC + H_BP);
   localparam logic [9:0] H_END       = 10'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
   localparam logic [9:0] V_SYNC_LAST = 10'(V_SYNC - 1);
   localparam logic [9:0] V_START     = 10'(V_SYNC + V_BP);
   localparam logic [9:0] V_END       = 10'(V_SYNC + V_BP + V_ACTIVE);

   typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

   state_t     state_q, state_d;
   logic       hs_q, hs_d, hs_p_q, hs_p_d, vs_q, vs_d, vs_line_q, vs_line_d;
   logic [9:0] hpos_q, hpos_d, vline_q, vline_d;
   logic [7:0] good_q, good_d, errcnt_q, errcnt_d;
   logic       herr_q, herr_d, verr_q, verr_d;
   logic       h_rise, h_fall, v_act, v_rise, v_fall, h_viol, v_viol, in_win;

   // vSync is only meaningful at line starts, so its edges are taken from the level
   // sampled at each hSync assertion edge (vs_line_q holds the previous line's level).
   always_comb begin
      hs_d      = hSync;
      hs_p_d    = hs_q;
      vs_d      = vSync;
      h_rise    = hs_q == SYNC_POL && hs_p_q != SYNC_POL;
      h_fall    = hs_q != SYNC_POL && hs_p_q == SYNC_POL;
      v_act     = vs_q == SYNC_POL;
      v_rise    = h_rise && v_act && !vs_line_q;
      v_fall    = h_rise && !v_act && vs_line_q;
      vs_line_d = h_rise ? v_act : vs_line_q;
      hpos_d    = (h_rise || hpos_q == H_LAST) ? '0 : hpos_q + 10'd1;
      vline_d   = !h_rise ? vline_q : (v_rise || vline_q == V_LAST) ? '0 : vline_q + 10'd1;
      h_viol    = (h_rise && hpos_q != H_LAST) || (!h_rise && hpos_q == H_LAST) ||
                  (h_fall && hpos_q != H_SYNC_LAST);
      v_viol    = (v_rise && vline_q != V_LAST) || (h_rise && !v_rise && vline_q == V_LAST) ||
                  (v_fall && vline_q != V_SYNC_LAST);
   end

   // Violations are ignored in SEARCH; in MEASURE they silently restart the search.
   always_comb begin
      state_d  = state_q;
      good_d   = good_q;
      herr_d   = 1'b0;
      verr_d   = 1'b0;
      errcnt_d = errcnt_q;
      if (state_q == SEARCH) begin
         if (v_rise) begin
            state_d = MEASURE;
            good_d  = '0;
         end
      end else if (h_viol || v_viol) begin
         state_d = SEARCH;
         if (state_q == LOCKED) begin
            herr_d   = h_viol;
            verr_d   = v_viol;
            errcnt_d = errcnt_q == 8'hFF ? errcnt_q : errcnt_q + 8'd1;
         end
      end else if (state_q == MEASURE && v_rise) begin
         good_d  = good_q + 8'd1;
         state_d = good_d == 8'(LOCK_FRAMES) ? LOCKED : MEASURE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         hs_q      <= ~SYNC_POL;
         hs_p_q    <= ~SYNC_POL;
         vs_q      <= ~SYNC_POL;
         vs_line_q <= 1'b0;
         hpos_q    <= '0;
         vline_q   <= '0;
         good_q    <= '0;
         errcnt_q  <= '0;
         herr_q    <= 1'b0;
         verr_q    <= 1'b0;
         state_q   <= SEARCH;
      end else begin
         hs_q      <= hs_d;
         hs_p_q    <= hs_p_d;
         vs_q      <= vs_d;
         vs_line_q <= vs_line_d;
         hpos_q    <= hpos_d;
         vline_q   <= vline_d;
         good_q    <= good_d;
         errcnt_q  <= errcnt_d;
         herr_q    <= herr_d;
         verr_q    <= verr_d;
         state_q   <= state_d;
      end
   end

   assign in_win        = hpos_q >= H_START && hpos_q < H_END && vline_q >= V_START && vline_q < V_END;
   assign column        = in_win ? hpos_q - H_START : '0;
   assign row           = in_win ? 9'(vline_q - V_START) : '0;
   assign locked        = state_q == LOCKED;
   assign displayActive = in_win && locked;
   assign frameStart    = displayActive && row == '0 && column == '0;
   assign hErr          = herr_q;
   assign vErr          = verr_q;
   assign errCount      = errcnt_q;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed checks of vga_sync_decoder on a scaled-down timing
module tb_vga_sync_decoder;
   localparam int HA = 4, HF = 1, HS = 2, HB = 1, HT = HA + HF + HS + HB;
   localparam int VA = 3, VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;
   localparam int FR = HT * VT;

   logic       clk = 1'b0, rst = 1'b0, hSync = 1'b1, vSync = 1'b1;
   logic [8:0] row;
   logic [9:0] column;
   logic       displayActive, frameStart, locked, hErr, vErr;
   logic [7:0] errCount;

   int checks = 0, failures = 0;
   int cyc = 0, ph = 0, pv = 0, c0 = 0, c3 = 0;
   int n_herr, n_verr, n_fs, n_da, pix_bad, max_row, max_col;
   int lock_cyc, unlock_cyc, herr_cyc, verr_cyc, fs_cyc, fs_gap, first_fs, first_da, da_rise, da_run;
   bit model_on = 1'b0, prev_locked = 1'b0, prev_da = 1'b0;

   vga_sync_decoder #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SYNC_POL(1'b0), .LOCK_FRAMES(2)
   ) dut (
      .clk(clk), .rst(rst), .hSync(hSync), .vSync(vSync),
      .row(row), .column(column), .displayActive(displayActive), .frameStart(frameStart),
      .locked(locked), .hErr(hErr), .vErr(vErr), .errCount(errCount)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clr();
      n_herr = 0; n_verr = 0; n_fs = 0; n_da = 0; pix_bad = 0;
      max_row = -1; max_col = -1; first_da = 0; da_run = 0; fs_gap = 0;
      herr_cyc = -1; unlock_cyc = -2; verr_cyc = -3;
   endtask

   // drive one input sample (px, ln = generator position); the DUT then shows the previous position
   task automatic step(input logic h, input logic v, input int px, input int ln);
      bit vis;
      hSync = h;
      vSync = v;
      @(posedge clk);
      #1;
      cyc++;
      if (hErr) begin n_herr++; herr_cyc = cyc; end
      if (vErr) begin n_verr++; verr_cyc = cyc; end
      if (frameStart) begin
         if (n_fs == 0) first_fs = cyc; else fs_gap = cyc - fs_cyc;
         fs_cyc = cyc;
         n_fs++;
      end
      if (displayActive) begin
         n_da++;
         if (!prev_da) begin
            da_rise = cyc;
            if (first_da == 0) first_da = cyc;
         end
         if (int'(row) > max_row) max_row = int'(row);
         if (int'(column) > max_col) max_col = int'(column);
      end else if (prev_da) da_run = cyc - da_rise;
      prev_da = displayActive;
      if (locked && !prev_locked && lock_cyc == 0) lock_cyc = cyc;
      if (!locked && prev_locked) unlock_cyc = cyc;
      prev_locked = locked;
      if (model_on) begin
         vis = ph >= HS + HB && ph < HS + HB + HA && pv >= VS + VB && pv < VS + VB + VA;
         if (displayActive !== vis || column !== 10'(vis ? ph - HS - HB : 0) ||
             row !== 9'(vis ? pv - VS - VB : 0)) pix_bad++;
      end
      ph = px;
      pv = ln;
   endtask

   task automatic line(input int len, input int hw, input bit vact, input int ln);
      for (int i = 0; i < len; i++) step(i < hw ? 1'b0 : 1'b1, vact ? 1'b0 : 1'b1, i, ln);
   endtask

   // vsw = vSync lines (0 suppresses it); line bl gets length blen and hSync width bhw
   task automatic frame(input int vsw, input int bl, input int blen, input int bhw);
      for (int l = 0; l < VT; l++) line(l == bl ? blen : HT, l == bl ? bhw : HS, l < vsw, l);
   endtask

   task automatic clean();
      frame(VS, -1, HT, HS);
   endtask

   task automatic relock(input string tag);
      clean();
      clean();
      chk({tag, "_early"}, 32'(locked), 0);
      clean();
      chk(tag, 32'(locked), 1);
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_row"}, 32'(row), 0);
      chk({tag, "_column"}, 32'(column), 0);
      chk({tag, "_da"}, 32'(displayActive), 0);
      chk({tag, "_fs"}, 32'(frameStart), 0);
      chk({tag, "_locked"}, 32'(locked), 0);
      chk({tag, "_herr"}, 32'(hErr), 0);
      chk({tag, "_verr"}, 32'(vErr), 0);
      chk({tag, "_cnt"}, 32'(errCount), 0);
   endtask

   initial begin
      clr();
      lock_cyc = 0;
      repeat (3) step(1'b1, 1'b1, 0, 0);
      check_idle("rst");
      rst = 1'b1;
      step(1'b1, 1'b1, 0, 0);
      c0 = cyc;
      clean();
      clean();
      chk("lock_pre", 32'(locked), 0);
      clean();
      chk("lock_cyc", lock_cyc - c0, 2 * FR + 2);
      chk("fs_first", first_fs - c0, 2 * FR + (VS + VB) * HT + HS + HB + 2);

      clr();
      c3 = cyc;
      model_on = 1'b1;
      clean();
      clean();
      model_on = 1'b0;
      chk("pix_model", pix_bad, 0);
      chk("fs_count", n_fs, 2);
      chk("fs_gap", fs_gap, FR);
      chk("da_cycles", n_da, 2 * HA * VA);
      chk("da_first", first_da - c3, (VS + VB) * HT + HS + HB + 2);
      chk("da_run", da_run, HA);
      chk("row_last", max_row, VA - 1);
      chk("col_last", max_col, HA - 1);
      chk("no_err", n_herr + n_verr, 0);

      clr();
      frame(VS, 4, HT - 1, HS);
      chk("hlen_herr", n_herr, 1);
      chk("hlen_verr", n_verr, 0);
      chk("hlen_cnt", 32'(errCount), 1);
      chk("hlen_same_edge", unlock_cyc, herr_cyc);
      chk("hlen_locked", 32'(locked), 0);
      relock("hlen_relock");

      clr();
      frame(0, -1, HT, HS);
      chk("vsup_verr", n_verr, 1);
      chk("vsup_herr", n_herr, 0);
      chk("vsup_cnt", 32'(errCount), 2);
      chk("vsup_same_edge", unlock_cyc, verr_cyc);
      relock("vsup_relock");

      clr();
      frame(VS, 4, HT, HS - 1);
      chk("hw_herr", n_herr, 1);
      chk("hw_verr", n_verr, 0);
      chk("hw_cnt", 32'(errCount), 3);
      relock("hw_relock");

      clr();
      frame(VS + 1, -1, HT, HS);
      chk("vw_verr", n_verr, 1);
      chk("vw_herr", n_herr, 0);
      chk("vw_cnt", 32'(errCount), 4);
      relock("vw_relock");

      clr();
      frame(VS, VT - 1, HT - 1, HS);
      frame(0, -1, HT, HS);
      chk("both_herr", n_herr, 1);
      chk("both_verr", n_verr, 1);
      chk("both_same_cycle", herr_cyc, verr_cyc);
      chk("both_cnt", 32'(errCount), 5);
      relock("both_relock");

      for (int l = 0; l < 4; l++) line(HT, HS, l < VS, l);
      for (int i = 0; i < 5; i++) step(i < HS ? 1'b0 : 1'b1, 1'b1, i, 4);
      chk("pre_rst_da", 32'(displayActive), 1);
      rst = 1'b0;
      step(1'b1, 1'b1, 5, 4);
      rst = 1'b1;
      check_idle("mid_rst");
      for (int i = 6; i < HT; i++) step(1'b1, 1'b1, i, 4);
      for (int l = 5; l < VT; l++) line(HT, HS, l < VS, l);
      relock("rst_relock");

      clr();
      repeat (255) begin
         frame(0, -1, HT, HS);
         clean();
         clean();
         clean();
      end
      chk("sat_255", 32'(errCount), 255);
      chk("sat_locked", 32'(locked), 1);
      repeat (2) begin
         frame(0, -1, HT, HS);
         clean();
         clean();
         clean();
      end
      chk("sat_hold", 32'(errCount), 255);
      chk("sat_pulses", n_verr, 257);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
